fetch_stage: RTL and testbench

//  Instruction-fetch stage of the RISC-V core. It holds the program counter and drives the

---
 rtl/fetch_stage.sv | 79 +++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RISC-V instruction fetch. Holds the PC, addresses the ROM and
//            loads the IF/ID register. Supports stall, flush and redirect.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int          A_WIDTH   = 20,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4,
    output logic               id_valid,
    output logic               misalign_err
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        target_misaligned;

    assign pc_plus4          = pc + 32'd4;
    assign imem_addr         = pc[A_WIDTH-1:0];
    assign target_misaligned = |redirect_target[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_target[31:2], 2'b00};
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    // Redirect outranks stall so the wrong-path word never reaches decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr    <= NOP_INSTR;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd0;
            id_valid    <= 1'b0;
        end else if (redirect_valid) begin
            id_instr    <= NOP_INSTR;
            id_valid    <= 1'b0;
        end else if (stall) begin
            id_instr    <= id_instr;
            id_valid    <= id_valid;
        end else if (flush) begin
            id_instr    <= NOP_INSTR;
            id_valid    <= 1'b0;
        end else begin
            id_instr    <= imem_data;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && target_misaligned) begin
            misalign_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [19:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] id_instr, id_pc, id_pc_plus4;
    logic        id_valid, misalign_err;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.A_WIDTH(20), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        logic [31:0] h;
        case (a)
            20'd0: return 8'h13;
            20'd1: return 8'h05;
            20'd2: return 8'h00;
            20'd3: return 8'h00;
            default: begin
                h = {12'd0, a} * 32'd2654435761;
                return h[23:16] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] rom_word(input logic [19:0] a);
        return {rom_byte(a), rom_byte(a + 20'd1), rom_byte(a + 20'd2), rom_byte(a + 20'd3)};
    endfunction

    assign imem_data = rom_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the priority rules applied to abstract state.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid, m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_instr <= NOP; m_ipc <= 32'h0; m_ipc4 <= 32'h0;
            m_valid <= 1'b0; m_mis <= 1'b0;
        end else if (redirect_valid) begin
            m_pc    <= redirect_target - (redirect_target % 4);
            m_instr <= NOP;
            m_valid <= 1'b0;
            if (redirect_target % 4 != 0) m_mis <= 1'b1;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (flush) begin
            m_pc    <= m_pc + 32'd4;
            m_instr <= NOP;
            m_valid <= 1'b0;
        end else begin
            m_instr <= rom_word(m_pc[19:0]);
            m_ipc   <= m_pc;
            m_ipc4  <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_pc    <= m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        chk("imem_addr", {12'd0, imem_addr}, {12'd0, m_pc[19:0]});
        chk("id_instr", id_instr, m_instr);
        chk("id_pc", id_pc, m_ipc);
        chk("id_pc_plus4", id_pc_plus4, m_ipc4);
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    end

    // Called at posedge+1; applies inputs for the next edge and advances.
    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall = s; flush = f; redirect_valid = r; redirect_target = t;
        @(posedge clk); #1;
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        chk("T1_rst_addr", {12'd0, imem_addr}, 32'h0);
        chk("T1_rst_valid", {31'd0, id_valid}, 32'h0);
        chk("T1_rst_instr", id_instr, NOP);
        rst_n = 1'b1;

        step(0, 0, 0, 0);
        chk("T1_instr", id_instr, 32'h1305_0000);
        chk("T1_pc", id_pc, 32'h0);
        chk("T1_pc4", id_pc_plus4, 32'h4);
        chk("T1_valid", {31'd0, id_valid}, 32'h1);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk("T2_pc", id_pc, 32'(i * 4));
            chk("T2_instr", id_instr, rom_word(20'(i * 4)));
        end

        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("T3_addr", {12'd0, imem_addr}, 32'h10);
            chk("T3_pc", id_pc, 32'hC);
        end
        step(0, 0, 0, 0);
        chk("T3_rel0", id_pc, 32'h10);
        step(0, 0, 0, 0);
        chk("T3_rel1", id_pc, 32'h14);

        step(0, 0, 1, 32'h40);
        chk("T4_valid", {31'd0, id_valid}, 32'h0);
        chk("T4_nop", id_instr, NOP);
        chk("T4_hold_pc", id_pc, 32'h14);
        step(0, 0, 0, 0);
        chk("T4_pc", id_pc, 32'h40);
        chk("T4_pc4", id_pc_plus4, 32'h44);
        step(1, 0, 1, 32'h80);
        chk("T4_stall_valid", {31'd0, id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("T4_stall_pc", id_pc, 32'h80);
        step(0, 0, 1, 32'h100);
        step(0, 0, 1, 32'h200);
        chk("T4_b2b_valid", {31'd0, id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("T4_b2b_pc", id_pc, 32'h200);

        step(0, 1, 0, 0);
        chk("FL_valid", {31'd0, id_valid}, 32'h0);
        chk("FL_hold_pc", id_pc, 32'h200);
        step(1, 1, 0, 0);
        chk("FL_stall_addr", {12'd0, imem_addr}, 32'h208);
        step(0, 0, 0, 0);
        chk("FL_pc", id_pc, 32'h208);

        chk("T5_pre", {31'd0, misalign_err}, 32'h0);
        step(0, 0, 1, 32'h46);
        chk("T5_err", {31'd0, misalign_err}, 32'h1);
        chk("T5_addr", {12'd0, imem_addr}, 32'h44);
        step(0, 0, 0, 0);
        chk("T5_pc", id_pc, 32'h44);
        step(0, 0, 1, 32'h300);
        chk("T5_sticky", {31'd0, misalign_err}, 32'h1);

        step(0, 0, 1, 32'hFFFF_FFFC);
        chk("T6_addr_top", {12'd0, imem_addr}, 32'hF_FFFC);
        step(0, 0, 0, 0);
        chk("T6_pc", id_pc, 32'hFFFF_FFFC);
        chk("T6_wrap4", id_pc_plus4, 32'h0);
        chk("T6_wrap_addr", {12'd0, imem_addr}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("T6_async_valid", {31'd0, id_valid}, 32'h0);
        chk("T6_async_pc", id_pc, 32'h0);
        chk("T6_async_pc4", id_pc_plus4, 32'h0);
        chk("T6_async_instr", id_instr, NOP);
        chk("T6_async_err", {31'd0, misalign_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic        s, f, r;
            logic [31:0] t;
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 15);
            r = ($urandom_range(0, 99) < 10);
            t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(1, 7)) rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                step(s, f, r, t);
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
